gmsk_burst_sequencer: RTL and testbench

//  Next-generation GMSK modulator timing/feeding block: primes the modulator, arms, then on fire_burst

---
 rtl/gmsk_pkg.sv | 18 +
 rtl/sample_strobe_gen.sv | 27 ++
 rtl/gmsk_burst_sequencer.sv | 141 ++++++++++++++
 tb/tb_gmsk_burst_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmsk_pkg.sv
// Shared state encoding and default sizing for the GMSK burst sequencer.
package gmsk_pkg;

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_ARMED = 2'd1,
        ST_BURST = 2'd2,
        ST_TAIL  = 2'd3
    } state_t;

    localparam int unsigned SAMPLE_BITS_DEF       = 8;
    localparam int unsigned CLOCKS_PER_SAMPLE_DEF = 4;
    localparam int unsigned PRIME_SYMBOLS_DEF     = 7;
    localparam int unsigned BURST_SYMBOLS_DEF     = 148;
    localparam int unsigned TAIL_SYMBOLS_DEF      = 3;
    localparam int unsigned CNT_BITS_DEF          = 8;

endpackage

// File: rtl/sample_strobe_gen.sv
// Free-running divider producing a one-clock sample strobe every CLOCKS_PER_SAMPLE clocks.
module sample_strobe_gen
    import gmsk_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_SAMPLE = CLOCKS_PER_SAMPLE_DEF
) (
    input  logic clock,
    input  logic reset_n,
    output logic sample_strobe
);

    localparam int unsigned DIV_BITS = $clog2(CLOCKS_PER_SAMPLE);
    localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(CLOCKS_PER_SAMPLE - 1);

    logic [DIV_BITS-1:0] div;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            div           <= '0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= (div == DIV_LAST);
            div           <= (div == DIV_LAST) ? '0 : div + DIV_BITS'(1);
        end
    end

endmodule

// File: rtl/gmsk_burst_sequencer.sv
// GMSK modulator feeder: primes, arms, streams a data burst plus tail, and gates I/Q to the RF chain.
module gmsk_burst_sequencer
    import gmsk_pkg::*;
#(
    parameter int unsigned SAMPLE_BITS       = SAMPLE_BITS_DEF,
    parameter int unsigned CLOCKS_PER_SAMPLE = CLOCKS_PER_SAMPLE_DEF,
    parameter int unsigned PRIME_SYMBOLS     = PRIME_SYMBOLS_DEF,
    parameter int unsigned BURST_SYMBOLS     = BURST_SYMBOLS_DEF,
    parameter int unsigned TAIL_SYMBOLS      = TAIL_SYMBOLS_DEF,
    parameter int unsigned CNT_BITS          = CNT_BITS_DEF
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   next_symbol_strobe,
    output logic                   current_symbol,
    output logic                   sample_strobe,
    input  logic                   fire_burst,
    output logic                   is_armed,
    output logic                   burst_done,
    input  logic                   sym_data,
    output logic                   sym_ready,
    input  logic [SAMPLE_BITS-1:0] modulator_inphase,
    input  logic [SAMPLE_BITS-1:0] modulator_quadrature,
    output logic [SAMPLE_BITS-1:0] rfchain_inphase,
    output logic [SAMPLE_BITS-1:0] rfchain_quadrature,
    output logic                   iq_valid
);

    localparam logic [CNT_BITS-1:0] PRIME_LAST = CNT_BITS'(PRIME_SYMBOLS - 1);
    localparam logic [CNT_BITS-1:0] BURST_LAST = CNT_BITS'(BURST_SYMBOLS - 1);
    localparam logic [CNT_BITS-1:0] TAIL_LAST  = CNT_BITS'(TAIL_SYMBOLS - 1);

    state_t              state, state_nx;
    logic [CNT_BITS-1:0] cnt, cnt_nx;
    logic                strobe_prev;
    logic                sym_ev_c;
    logic                sending_c;
    logic                cur_sym_nx, sym_ready_nx, burst_done_nx;

    sample_strobe_gen #(
        .CLOCKS_PER_SAMPLE(CLOCKS_PER_SAMPLE)
    ) u_strobe (
        .clock        (clock),
        .reset_n      (reset_n),
        .sample_strobe(sample_strobe)
    );

    // One event per rising edge of the modulator's symbol strobe.
    assign sym_ev_c  = next_symbol_strobe & ~strobe_prev;
    assign sending_c = (state == ST_BURST) || (state == ST_TAIL);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state              <= ST_PRIME;
            cnt                <= '0;
            strobe_prev        <= 1'b0;
            current_symbol     <= 1'b1;
            is_armed           <= 1'b0;
            burst_done         <= 1'b0;
            sym_ready          <= 1'b0;
            iq_valid           <= 1'b0;
            rfchain_inphase    <= '0;
            rfchain_quadrature <= '0;
        end else begin
            state              <= state_nx;
            cnt                <= cnt_nx;
            strobe_prev        <= next_symbol_strobe;
            current_symbol     <= cur_sym_nx;
            is_armed           <= (state_nx == ST_ARMED);
            burst_done         <= burst_done_nx;
            sym_ready          <= sym_ready_nx;
            iq_valid           <= sending_c;
            rfchain_inphase    <= sending_c ? modulator_inphase    : '0;
            rfchain_quadrature <= sending_c ? modulator_quadrature : '0;
        end
    end

    // Next-state, counter and symbol-feed decisions.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        cur_sym_nx    = current_symbol;
        sym_ready_nx  = 1'b0;
        burst_done_nx = 1'b0;
        case (state)
            ST_PRIME: begin
                cur_sym_nx = 1'b1;
                if (sym_ev_c) begin
                    if (cnt == PRIME_LAST) begin
                        state_nx = ST_ARMED;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_BITS'(1);
                    end
                end
            end
            ST_ARMED: begin
                cur_sym_nx = 1'b1;
                // A symbol edge coinciding with the fire request is not a data symbol.
                if (fire_burst) begin
                    state_nx = ST_BURST;
                    cnt_nx   = '0;
                end
            end
            ST_BURST: begin
                if (sym_ev_c) begin
                    cur_sym_nx   = sym_data;
                    sym_ready_nx = 1'b1;
                    if (cnt == BURST_LAST) begin
                        cnt_nx = '0;
                        if (TAIL_SYMBOLS == 0) begin
                            state_nx      = ST_ARMED;
                            burst_done_nx = 1'b1;
                        end else begin
                            state_nx = ST_TAIL;
                        end
                    end else begin
                        cnt_nx = cnt + CNT_BITS'(1);
                    end
                end
            end
            ST_TAIL: begin
                if (sym_ev_c) begin
                    cur_sym_nx = 1'b1;
                    if (cnt == TAIL_LAST) begin
                        state_nx      = ST_ARMED;
                        cnt_nx        = '0;
                        burst_done_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + CNT_BITS'(1);
                    end
                end
            end
            default: begin
                state_nx = ST_PRIME;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// Self-checking bench: directed stimulus, per-cycle behavioural model compare, literal spot checks.
module tb_gmsk_burst_sequencer;

    localparam int SB    = 8;
    localparam int CPS   = 4;
    localparam int PRIME = 7;
    localparam int BURST = 4;
    localparam int TAIL  = 2;

    localparam int M_PRIME = 0;
    localparam int M_ARMED = 1;
    localparam int M_BURST = 2;
    localparam int M_TAIL  = 3;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          next_symbol_strobe;
    logic          current_symbol;
    logic          sample_strobe;
    logic          fire_burst;
    logic          is_armed;
    logic          burst_done;
    logic          sym_data;
    logic          sym_ready;
    logic [SB-1:0] modulator_inphase;
    logic [SB-1:0] modulator_quadrature;
    logic [SB-1:0] rfchain_inphase;
    logic [SB-1:0] rfchain_quadrature;
    logic          iq_valid;

    gmsk_burst_sequencer #(
        .SAMPLE_BITS      (SB),
        .CLOCKS_PER_SAMPLE(CPS),
        .PRIME_SYMBOLS    (PRIME),
        .BURST_SYMBOLS    (BURST),
        .TAIL_SYMBOLS     (TAIL),
        .CNT_BITS         (8)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .next_symbol_strobe  (next_symbol_strobe),
        .current_symbol      (current_symbol),
        .sample_strobe       (sample_strobe),
        .fire_burst          (fire_burst),
        .is_armed            (is_armed),
        .burst_done          (burst_done),
        .sym_data            (sym_data),
        .sym_ready           (sym_ready),
        .modulator_inphase   (modulator_inphase),
        .modulator_quadrature(modulator_quadrature),
        .rfchain_inphase     (rfchain_inphase),
        .rfchain_quadrature  (rfchain_quadrature),
        .iq_valid            (iq_valid)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_ready  = 0;
    int n_done   = 0;
    int cyc      = 0;
    int last_strobe = -1;
    bit chk_en   = 1'b0;

    // Model state: which phase, how many symbols seen in it, clocks since reset.
    int      m_phase;
    int      m_seen;
    int      m_clocks;
    logic    m_prev;
    logic    exp_sym, exp_strobe, exp_armed, exp_done, exp_ready, exp_valid;
    logic [SB-1:0] exp_i, exp_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Advance the model by one clock edge using the inputs presented at that edge.
    task automatic model_step();
        logic ev;
        if (!reset_n) begin
            m_phase = M_PRIME; m_seen = 0; m_clocks = 0; m_prev = 1'b0;
            exp_sym = 1'b1; exp_strobe = 1'b0; exp_armed = 1'b0; exp_done = 1'b0;
            exp_ready = 1'b0; exp_valid = 1'b0; exp_i = '0; exp_q = '0;
            return;
        end
        m_clocks++;
        exp_strobe = ((m_clocks % CPS) == 0);
        ev = next_symbol_strobe && !m_prev;
        m_prev = next_symbol_strobe;
        exp_valid = (m_phase == M_BURST) || (m_phase == M_TAIL);
        exp_i = exp_valid ? modulator_inphase : '0;
        exp_q = exp_valid ? modulator_quadrature : '0;
        exp_ready = 1'b0;
        exp_done  = 1'b0;
        if (m_phase == M_PRIME) begin
            if (ev) m_seen++;
            if (m_seen == PRIME) begin m_phase = M_ARMED; m_seen = 0; end
        end else if (m_phase == M_ARMED) begin
            if (fire_burst) begin m_phase = M_BURST; m_seen = 0; end
        end else if (m_phase == M_BURST) begin
            if (ev) begin
                exp_sym = sym_data; exp_ready = 1'b1; m_seen++;
                if (m_seen == BURST) begin
                    m_seen = 0;
                    if (TAIL == 0) begin m_phase = M_ARMED; exp_done = 1'b1; end
                    else m_phase = M_TAIL;
                end
            end
        end else begin
            if (ev) begin
                exp_sym = 1'b1; m_seen++;
                if (m_seen == TAIL) begin m_phase = M_ARMED; m_seen = 0; exp_done = 1'b1; end
            end
        end
        exp_armed = (m_phase == M_ARMED);
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset_n) last_strobe = -1;
            if (chk_en) begin
                check("current_symbol", current_symbol, exp_sym);
                check("sample_strobe", sample_strobe, exp_strobe);
                check("is_armed", is_armed, exp_armed);
                check("burst_done", burst_done, exp_done);
                check("sym_ready", sym_ready, exp_ready);
                check("iq_valid", iq_valid, exp_valid);
                check("rfchain_inphase", rfchain_inphase, exp_i);
                check("rfchain_quadrature", rfchain_quadrature, exp_q);
                if (sample_strobe) begin
                    if (last_strobe >= 0) check("strobe_period", cyc - last_strobe, CPS);
                    last_strobe = cyc;
                end
                if (sym_ready) n_ready++;
                if (burst_done) n_done++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        modulator_inphase    = SB'($urandom);
        modulator_quadrature = SB'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic sym_pulse(output logic sym_after);
        next_symbol_strobe = 1'b1;
        tick();
        sym_after = current_symbol;
        next_symbol_strobe = 1'b0;
        repeat (3) tick();
    endtask

    logic s;
    logic got[$];
    int   r0, d0;

    initial begin
        logic pat[4];
        logic exp_seq[6];
        pat     = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        reset_n = 1'b0; next_symbol_strobe = 1'b0; fire_burst = 1'b0; sym_data = 1'b0;
        modulator_inphase = '0; modulator_quadrature = '0;

        // Reset held for three clocks
        idle(3);
        chk_en = 1'b1;
        check("reset_is_armed", is_armed, 0);
        check("reset_current_symbol", current_symbol, 1);
        check("reset_iq_valid", iq_valid, 0);
        reset_n = 1'b1;

        // Priming, with a fire request that must be ignored
        idle(2);
        fire_burst = 1'b1; tick(); fire_burst = 1'b0;
        repeat (PRIME - 1) sym_pulse(s);
        check("prime_not_armed_yet", is_armed, 0);
        sym_pulse(s);
        check("prime_armed", is_armed, 1);
        check("prime_iq_valid", iq_valid, 0);
        check("prime_rf_i", rfchain_inphase, 0);
        idle(2);

        // Burst 1,0,1,1 plus two tail symbols, with a mid-burst fire to ignore
        r0 = n_ready; d0 = n_done;
        fire_burst = 1'b1; tick(); fire_burst = 1'b0;
        idle(1);
        for (int i = 0; i < BURST; i++) begin
            sym_data = pat[i];
            sym_pulse(s);
            got.push_back(s);
            if (i == 1) begin
                check("burst_iq_valid", iq_valid, 1);
                fire_burst = 1'b1; tick(); fire_burst = 1'b0;
            end
        end
        for (int i = 0; i < TAIL; i++) begin
            sym_pulse(s);
            got.push_back(s);
        end
        for (int i = 0; i < 6; i++) check($sformatf("burst_symbol_%0d", i), got[i], exp_seq[i]);
        check("burst_ready_count", n_ready - r0, 4);
        check("burst_done_count", n_done - d0, 1);
        check("burst_rearmed", is_armed, 1);
        check("burst_iq_off", iq_valid, 0);
        idle(4);
        check("no_extra_burst", n_done - d0, 1);

        // Fire on the same clock as a symbol edge: that edge carries no data
        r0 = n_ready; d0 = n_done;
        fire_burst = 1'b1; next_symbol_strobe = 1'b1; tick();
        fire_burst = 1'b0; next_symbol_strobe = 1'b0;
        check("simul_symbol_held", current_symbol, 1);
        idle(3);
        check("simul_no_ready", n_ready - r0, 0);
        sym_data = 1'b0;
        sym_pulse(s);
        check("simul_first_data", s, 0);
        sym_data = 1'b1;
        repeat (BURST - 1 + TAIL) sym_pulse(s);
        check("simul_ready_count", n_ready - r0, 4);
        check("simul_done_count", n_done - d0, 1);

        // Abort mid-burst with reset, then re-prime
        fire_burst = 1'b1; tick(); fire_burst = 1'b0;
        idle(1);
        sym_data = 1'b0;
        sym_pulse(s);
        sym_pulse(s);
        check("abort_pre_symbol", current_symbol, 0);
        d0 = n_done;
        reset_n = 1'b0; tick();
        check("abort_iq_valid", iq_valid, 0);
        check("abort_rf_q", rfchain_quadrature, 0);
        check("abort_current_symbol", current_symbol, 1);
        check("abort_sym_ready", sym_ready, 0);
        reset_n = 1'b1;
        idle(8);
        check("abort_no_done", n_done - d0, 0);
        repeat (PRIME) sym_pulse(s);
        check("reprime_armed", is_armed, 1);
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
